rv32i_mem_access_ctrl: RTL



---
 rtl/rv32i_mem_pkg.sv | 31 +++
 rtl/rv32i_mem_access_ctrl_if.sv | 25 ++
 rtl/rv32i_lane_align.sv | 31 +++
 rtl/rv32i_mem_access_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the RV32I data-port load/store controller.
// Optional feature macro: RV32I_MISALIGN_TRAP_EN (see rv32i_mem_access_ctrl).
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_ILL  = 2'b11
    } mem_width_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_BEAT1 = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } mem_state_e;

    function automatic logic [3:0] width_mask(input logic [1:0] width);
        logic [3:0] mask;
        case (width)
            MEM_BYTE: mask = 4'b0001;
            MEM_HALF: mask = 4'b0011;
            MEM_WORD: mask = 4'b1111;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rv32i_mem_access_ctrl_if.sv
// Request/response bus between the core load/store path and the memory access controller.
interface rv32i_mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_width;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_width, req_sign, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/rv32i_lane_align.sv
// Combinational byte-lane alignment: byte enables and shifted store data over two
// words, plus extraction and sign/zero extension of a two-word read window.
module rv32i_lane_align
    import rv32i_mem_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  off_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rd64_i,
    output logic [7:0]  be8_o,
    output logic [63:0] wd64_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rd_lo_s;

    // Lane shift for stores and right-justify plus extend for loads.
    always_comb begin
        be8_o   = {4'b0000, width_mask(width_i)} << off_i;
        wd64_o  = {32'h0000_0000, wdata_i} << {off_i, 3'b000};
        rd_lo_s = 32'(rd64_i >> {off_i, 3'b000});
        case (width_i)
            MEM_BYTE: rdata_o = {{24{sign_i & rd_lo_s[7]}}, rd_lo_s[7:0]};
            MEM_HALF: rdata_o = {{16{sign_i & rd_lo_s[15]}}, rd_lo_s[15:0]};
            MEM_WORD: rdata_o = rd_lo_s;
            default:  rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_access_ctrl.sv
// Load/store sequencer for the word-addressed RAM data port; splits word-crossing accesses
// into two beats. Define RV32I_MISALIGN_TRAP_EN to reject crossing accesses instead.
module rv32i_mem_access_ctrl
    import rv32i_mem_pkg::*;
#(
    parameter int RAM_AW = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    rv32i_mem_access_ctrl_if.slave bus,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    mem_state_e        state_q;
    logic              we_q;
    logic [1:0]        width_q;
    logic              sign_q;
    logic [1:0]        off_q;
    logic [RAM_AW-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_buf_q;

    logic [7:0]        be8_s;
    logic [63:0]       wd64_s;
    logic [63:0]       rd64_s;
    logic [31:0]       ext_s;
    logic              split_s;
    logic              reject_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^bus.req_addr[31:RAM_AW+2];

`ifdef RV32I_MISALIGN_TRAP_EN
    logic [7:0] be8_in_s;
    assign be8_in_s = {4'b0000, width_mask(bus.req_width)} << bus.req_addr[1:0];
    assign reject_s = (bus.req_width == MEM_ILL) || (be8_in_s[7:4] != 4'b0000);
`else
    assign reject_s = (bus.req_width == MEM_ILL);
`endif

    assign split_s = (be8_s[7:4] != 4'b0000);
    assign rd64_s  = split_s ? {ram_rdata, lo_buf_q} : {32'h0000_0000, ram_rdata};

    rv32i_lane_align u_align (
        .width_i (width_q),
        .off_i   (off_q),
        .sign_i  (sign_q),
        .wdata_i (wdata_q),
        .rd64_i  (rd64_s),
        .be8_o   (be8_s),
        .wd64_o  (wd64_s),
        .rdata_o (ext_s)
    );

    // Sequencer state and latched request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            width_q  <= 2'b00;
            sign_q   <= 1'b0;
            off_q    <= 2'b00;
            idx_q    <= '0;
            wdata_q  <= 32'h0000_0000;
            lo_buf_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        width_q <= bus.req_width;
                        sign_q  <= bus.req_sign;
                        off_q   <= bus.req_addr[1:0];
                        idx_q   <= bus.req_addr[RAM_AW+1:2];
                        wdata_q <= bus.req_wdata;
                        state_q <= reject_s ? ST_ERR : ST_BEAT0;
                    end
                end
                ST_BEAT0: state_q <= split_s ? ST_BEAT1 : ST_DONE;
                ST_BEAT1: begin
                    lo_buf_q <= ram_rdata;
                    state_q  <= ST_DONE;
                end
                ST_DONE:  state_q <= ST_IDLE;
                ST_ERR:   state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // RAM beat drive and response decode from the registered state.
    always_comb begin
        ram_addr  = idx_q;
        ram_be    = 4'b0000;
        ram_wdata = wd64_s[31:0];
        ram_we    = 1'b0;
        case (state_q)
            ST_BEAT0: begin
                ram_be = be8_s[3:0];
                ram_we = we_q & ~reset;
            end
            ST_BEAT1: begin
                ram_addr  = idx_q + RAM_AW'(1);
                ram_be    = be8_s[7:4];
                ram_wdata = wd64_s[63:32];
                ram_we    = we_q & ~reset;
            end
            default: ram_we = 1'b0;
        endcase
        bus.req_ready = (state_q == ST_IDLE) & ~reset;
        bus.rsp_valid = ((state_q == ST_DONE) || (state_q == ST_ERR)) & ~reset;
        bus.rsp_err   = (state_q == ST_ERR) & ~reset;
        bus.rsp_rdata = ((state_q == ST_DONE) && !we_q && !reset) ? ext_s : 32'h0000_0000;
    end

endmodule
